vec_mem_arbiter: RTL and testbench

- Shares one native picorv32-style memory port between the scalar core (instruction and data fetches) and the vector coprocessor's load/store unit.
- Sits between picorv32 / picorv32_pcpi_vec and the single memory or bus slave.
- Holds each grant for exactly one complete valid/ready transaction.
- Arbitrates by round-robin or vector-priority; vector-priority mode has a bounded CPU starvation window, so strided vector loads cannot lock out instruction fetch.

---
 rtl/vec_mem_arb_pkg.sv | 19 +
 rtl/vec_mem_arb_pick.sv | 31 +++
 rtl/vec_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_vec_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_arb_pkg.sv
// Shared types and constants for the vector/scalar memory-port arbiter.
package vec_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_CPU = 2'd1,
    ST_GNT_VEC = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_VEC = 1'b1;

  localparam int ARB_RR     = 0;
  localparam int ARB_VECPRI = 1;

  // Width of the consecutive-vector-grant counter (MAX_VEC_RUN <= 255).
  localparam int VEC_RUN_W = 8;

endpackage

// File: rtl/vec_mem_arb_pick.sv
// Combinational winner selection between the CPU and vector requesters.
module vec_mem_arb_pick
  import vec_mem_arb_pkg::*;
#(
  parameter int MAX_VEC_RUN = 8
) (
  input  logic                 cpu_valid,
  input  logic                 vec_valid,
  input  logic                 last_winner,
  input  logic [VEC_RUN_W-1:0] vec_run,
  input  logic                 mode,
  output logic                 winner,
  output logic                 any_req
);

  localparam logic [VEC_RUN_W-1:0] MAX_RUN = VEC_RUN_W'(MAX_VEC_RUN);

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    winner  = REQ_CPU;
    any_req = cpu_valid | vec_valid;
    if (vec_valid && !cpu_valid) begin
      winner = REQ_VEC;
    end else if (cpu_valid && vec_valid) begin
      // mode=1: vector priority, capped so the CPU cannot starve.
      if (mode) winner = (vec_run < MAX_RUN) ? REQ_VEC : REQ_CPU;
      else      winner = ~last_winner;
    end
  end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Shares one picorv32-style native memory port between the scalar core and
// the vector load/store unit; each grant covers exactly one valid/ready beat.
module vec_mem_arbiter
  import vec_mem_arb_pkg::*;
#(
  parameter int ARB_MODE    = ARB_RR,
  parameter int MAX_VEC_RUN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_vec
);

  localparam logic VEC_PRIORITY = (ARB_MODE == ARB_VECPRI);

  arb_state_e           state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_instr_q, mem_instr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wstrb_q, mem_wstrb_d;
  logic                 grant_vec_q, grant_vec_d;
  logic                 last_winner_q, last_winner_d;
  logic [VEC_RUN_W-1:0] vec_run_q, vec_run_d;
  logic                 winner;
  logic                 any_req;

  vec_mem_arb_pick #(
    .MAX_VEC_RUN(MAX_VEC_RUN)
  ) u_pick (
    .cpu_valid  (cpu_mem_valid),
    .vec_valid  (vec_mem_valid),
    .last_winner(last_winner_q),
    .vec_run    (vec_run_q),
    .mode       (VEC_PRIORITY),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_d       = state_q;
    mem_valid_d   = mem_valid_q;
    mem_instr_d   = mem_instr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    grant_vec_d   = grant_vec_q;
    last_winner_d = last_winner_q;
    vec_run_d     = vec_run_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          mem_valid_d   = 1'b1;
          last_winner_d = winner;
          if (winner == REQ_VEC) begin
            state_d     = ST_GNT_VEC;
            mem_instr_d = 1'b0;
            mem_addr_d  = vec_mem_addr;
            mem_wdata_d = vec_mem_wdata;
            mem_wstrb_d = vec_mem_wstrb;
            grant_vec_d = 1'b1;
            // Only contested vector wins count toward the starvation cap.
            if (VEC_PRIORITY && cpu_mem_valid && (vec_run_q != '1))
              vec_run_d = vec_run_q + VEC_RUN_W'(1);
          end else begin
            state_d     = ST_GNT_CPU;
            mem_instr_d = cpu_mem_instr;
            mem_addr_d  = cpu_mem_addr;
            mem_wdata_d = cpu_mem_wdata;
            mem_wstrb_d = cpu_mem_wstrb;
            grant_vec_d = 1'b0;
            vec_run_d   = '0;
          end
        end
      end
      ST_GNT_CPU, ST_GNT_VEC: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_valid_q   <= 1'b0;
      mem_instr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      grant_vec_q   <= 1'b0;
      last_winner_q <= REQ_VEC;
      vec_run_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_instr_q   <= mem_instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      grant_vec_q   <= grant_vec_d;
      last_winner_q <= last_winner_d;
      vec_run_q     <= vec_run_d;
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_instr     = mem_instr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign grant_vec     = grant_vec_q;
  assign cpu_mem_ready = (state_q == ST_GNT_CPU) && mem_ready;
  assign vec_mem_ready = (state_q == ST_GNT_VEC) && mem_ready;
  assign cpu_mem_rdata = mem_rdata;
  assign vec_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Scoreboard bench: one round-robin and one vector-priority (MAX_VEC_RUN=3)
// arbiter, each with its own slave model, requesters and monitor.
module tb_vec_mem_arbiter;
  import vec_mem_arb_pkg::*;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL i%0d %s got=%0h exp=%0h", inst, name, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0040_0113;
    return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int MODE = gi;
    localparam int MAXR = (gi == 0) ? 8 : 3;

    logic        reset;
    logic        cpu_valid, cpu_instr, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        vec_valid, vec_ready;
    logic [31:0] vec_addr, vec_wdata, vec_rdata;
    logic [3:0]  vec_wstrb;
    logic        mem_valid, mem_instr, mem_ready, grant_vec;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    vec_mem_arbiter #(.ARB_MODE(MODE), .MAX_VEC_RUN(MAXR)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_mem_valid(cpu_valid), .cpu_mem_instr(cpu_instr), .cpu_mem_addr(cpu_addr),
      .cpu_mem_wdata(cpu_wdata), .cpu_mem_wstrb(cpu_wstrb), .cpu_mem_ready(cpu_ready),
      .cpu_mem_rdata(cpu_rdata),
      .vec_mem_valid(vec_valid), .vec_mem_addr(vec_addr), .vec_mem_wdata(vec_wdata),
      .vec_mem_wstrb(vec_wstrb), .vec_mem_ready(vec_ready), .vec_mem_rdata(vec_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .grant_vec(grant_vec)
    );

    txn_t cpu_q[$];
    txn_t vec_q[$];
    logic grant_log[$];
    logic m_last = REQ_VEC;
    int   m_run  = 0;
    logic m_gv   = 1'b0;
    logic owner  = REQ_CPU;
    bit   mon_en = 1'b0;
    bit   done_l = 1'b0;
    int   slave_lat  = 1;
    bit   slave_rand = 1'b0;
    int   wait_cnt   = 1;

    // Slave: ready after wait_cnt cycles of mem_valid, data is a function of address.
    initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
        @(posedge clk);
        #1;
        if (mem_valid && !mem_ready) begin
          if (wait_cnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = slave_data(mem_addr);
          end else begin
            wait_cnt--;
            mem_rdata = $urandom;
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_cnt  = slave_rand ? int'($urandom_range(4, 1)) : slave_lat;
        end
      end
    end

    // Arbitration rules applied to the requests pending at the decision cycle.
    task automatic model_pick(input logic c, input logic v, output logic w);
      if (c && !v)           w = REQ_CPU;
      else if (!c && v)      w = REQ_VEC;
      else if (MODE == 0)    w = (m_last == REQ_VEC) ? REQ_CPU : REQ_VEC;
      else                   w = (m_run < MAXR) ? REQ_VEC : REQ_CPU;
      if (w == REQ_CPU)            m_run = 0;
      else if (c && m_run < 255)   m_run++;
      m_last = w;
    endtask

    task automatic model_clear();
      cpu_q.delete();
      vec_q.delete();
      grant_log.delete();
      m_last = REQ_VEC;
      m_run  = 0;
      m_gv   = 1'b0;
      owner  = REQ_CPU;
    endtask

    initial begin : monitor
      logic p_mv, p_mr, p_cv, p_vv;
      logic w;
      logic [68:0] fields;
      p_mv = 0; p_mr = 0; p_cv = 0; p_vv = 0;
      forever begin
        @(negedge clk);
        if (!mon_en) begin
          p_mv = 0; p_mr = 0; p_cv = 0; p_vv = 0;
        end else begin
          fields = {mem_instr, mem_addr, mem_wdata, mem_wstrb};
          if (!p_mv) begin
            check(gi, "grant_after_idle", mem_valid, p_cv | p_vv);
            if (mem_valid) begin
              model_pick(p_cv, p_vv, w);
              owner = w;
              m_gv  = w;
              grant_log.push_back(w);
            end
          end else if (p_mr) begin
            check(gi, "bubble_after_done", mem_valid, 1'b0);
          end else begin
            check(gi, "hold_valid", mem_valid, 1'b1);
          end
          if (mem_valid) begin
            if (owner == REQ_CPU) begin
              check(gi, "cpu_q_pending", cpu_q.size() != 0, 1'b1);
              if (cpu_q.size() != 0)
                check(gi, "cpu_bus_fields", fields,
                      {cpu_q[0].instr, cpu_q[0].addr, cpu_q[0].wdata, cpu_q[0].wstrb});
            end else begin
              check(gi, "vec_q_pending", vec_q.size() != 0, 1'b1);
              if (vec_q.size() != 0)
                check(gi, "vec_bus_fields", fields,
                      {1'b0, vec_q[0].addr, vec_q[0].wdata, vec_q[0].wstrb});
            end
          end
          check(gi, "grant_vec", grant_vec, m_gv);
          check(gi, "cpu_ready", cpu_ready, mem_valid && mem_ready && owner == REQ_CPU);
          check(gi, "vec_ready", vec_ready, mem_valid && mem_ready && owner == REQ_VEC);
          check(gi, "cpu_rdata_mirror", cpu_rdata, mem_rdata);
          check(gi, "vec_rdata_mirror", vec_rdata, mem_rdata);
          if (cpu_ready && cpu_q.size() != 0) begin
            txn_t t;
            t = cpu_q.pop_front();
            check(gi, "cpu_rdata", cpu_rdata, slave_data(t.addr));
          end
          if (vec_ready && vec_q.size() != 0) begin
            txn_t t;
            t = vec_q.pop_front();
            check(gi, "vec_rdata", vec_rdata, slave_data(t.addr));
          end
          p_mv = mem_valid; p_mr = mem_ready; p_cv = cpu_valid; p_vv = vec_valid;
        end
      end
    end

    task automatic cpu_txn(input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           output int cyc);
      txn_t t;
      t.instr = instr; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      cpu_q.push_back(t);
      cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr;
      cpu_wdata = wdata; cpu_wstrb = wstrb;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!cpu_ready && cyc < 200);
      check(gi, "cpu_done", cpu_ready, 1'b1);
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
    endtask

    task automatic vec_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int cyc);
      txn_t t;
      t.instr = 1'b0; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      vec_q.push_back(t);
      vec_valid = 1'b1; vec_addr = addr; vec_wdata = wdata; vec_wstrb = wstrb;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!vec_ready && cyc < 200);
      check(gi, "vec_done", vec_ready, 1'b1);
      @(posedge clk);
      #1;
      vec_valid = 1'b0;
    endtask

    task automatic cpu_rand(input int n);
      int cyc;
      repeat (n) begin
        repeat ($urandom_range(3, 0)) begin
          @(posedge clk);
          #1;
        end
        cpu_txn(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, $urandom,
                4'($urandom_range(15, 0)), cyc);
      end
    endtask

    task automatic vec_rand(input int n);
      int cyc;
      repeat (n) begin
        repeat ($urandom_range(3, 0)) begin
          @(posedge clk);
          #1;
        end
        vec_txn($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(15, 0)), cyc);
      end
    endtask

    task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      reset  = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      mon_en = 1'b1;
    endtask

    initial begin : seq
      int   cyc, c1, c2, n;
      logic exp_rr[6];
      logic exp_vp[8];
      reset = 1'b1;
      cpu_valid = 0; cpu_instr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
      vec_valid = 0; vec_addr = '0; vec_wdata = '0; vec_wstrb = '0;
      do_reset();
      check(gi, "reset_state",
            {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, grant_vec, cpu_ready, vec_ready},
            '0);

      // Lone CPU instruction read of address 0, 1-cycle slave.
      @(posedge clk);
      #1;
      cpu_txn(1'b1, 32'h0, 32'h0, 4'b0000, cyc);
      check(gi, "lone_cpu_latency", cyc, 3);

      // Lone vector byte write.
      vec_txn(32'd400, 32'h1122_3344, 4'b0001, cyc);
      check(gi, "lone_vec_latency", cyc, 3);

      // Both requesters continuously valid.
      do_reset();
      @(posedge clk);
      #1;
      fork
        repeat (MODE == 0 ? 3 : 2) cpu_txn(1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 4'hF, c1);
        repeat (MODE == 0 ? 3 : 6) vec_txn($urandom & 32'hFFFF_FFFC, $urandom, 4'h3, c2);
      join
      exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_vp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      n = (MODE == 0) ? 6 : 8;
      check(gi, "order_len", grant_log.size(), n);
      for (int k = 0; k < n && k < grant_log.size(); k++)
        check(gi, "grant_order", grant_log[k], (MODE == 0) ? exp_rr[k] : exp_vp[k]);

      // Slave stalls a vector grant; CPU arrives mid-grant and waits.
      do_reset();
      slave_lat = 5;
      @(posedge clk);
      #1;
      fork
        vec_txn(32'h0000_0800, 32'hCAFE_F00D, 4'b1100, c2);
        begin
          repeat (2) begin
            @(posedge clk);
            #1;
          end
          cpu_txn(1'b0, 32'h0000_0900, 32'h0, 4'b0000, c1);
        end
      join
      check(gi, "stall_order_len", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
        check(gi, "stall_first_vec", grant_log[0], REQ_VEC);
        check(gi, "stall_then_cpu", grant_log[1], REQ_CPU);
      end
      slave_lat = 1;

      // Reset while the CPU is granted and the slave has not answered.
      do_reset();
      slave_lat = 10;
      @(posedge clk);
      #1;
      begin
        txn_t t;
        t.instr = 1'b0; t.addr = 32'h100; t.wdata = 32'h55; t.wstrb = 4'b1111;
        cpu_q.push_back(t);
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h100;
        cpu_wdata = 32'h55; cpu_wstrb = 4'b1111;
      end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!mem_valid && cyc < 20);
      check(gi, "rst_mid_granted", mem_valid, 1'b1);
      #2;
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      check(gi, "rst_mid_bus", {mem_valid, cpu_ready, vec_ready, grant_vec, mem_addr}, '0);
      cpu_valid = 1'b0;
      slave_lat = 1;
      @(negedge clk);
      check(gi, "rst_mid_no_ready", {mem_valid, cpu_ready}, '0);
      reset = 1'b0;
      model_clear();
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      cpu_txn(1'b1, 32'h0000_0204, 32'h0, 4'b0000, cyc);
      check(gi, "post_rst_latency", cyc, 3);

      // Randomized traffic with random slave latency.
      slave_rand = 1'b1;
      fork
        cpu_rand(25);
        vec_rand(25);
      join
      slave_rand = 1'b0;
      repeat (3) @(posedge clk);
      done_l = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done_l && g_inst[1].done_l) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check(-1, "all_sequences_done", {g_inst[0].done_l, g_inst[1].done_l}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
